core_ctrl_fsm: RTL and testbench

//   Multi-cycle sequencer for the RV32I core. Consumes the decoder's fields and strobes
//   (opcode, func3, ecall/ebreak/mret/invalid). Drives the IR, PC, register-file and

---
 rtl/core_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm -- multi-cycle sequencer for the RV32I core.
//
// The sequencer runs one instruction at a time through FETCH, DECODE, EXEC,
// MEM, WB and TRAP. It takes the decoder's fields and strobes and drives the
// IR, PC, register-file and memory-bus enables. It also raises traps for the
// CSR unit.
//
// Optional build macro: CTRL_MISALIGN_TRAP_EN
//   When this macro is defined, EXEC checks load/store alignment using
//   func3[1:0] and mem_addr_lo. Misaligned accesses trap with cause 4 (load)
//   or 6 (store).
//
// Parameters:
//   MAX_WAIT  bus cycles allowed without an ack before an access-fault trap
//             (0 = never time out)
//   CNT_W     wait counter width, 2**CNT_W > MAX_WAIT
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   opcode, func3             decoded inst[6:2] and func3
//   ecall/ebreak/mret/invalid decoder strobes
//   br_taken, mem_addr_lo     ALU results, valid in EXEC
//   imem_ack, dmem_ack        bus completions
//   imem_req, dmem_req, dmem_we     bus requests
//   ir_we, pc_we, pc_sel, rf_we     datapath enables (pc_sel: 0 PC+4, 1 target, 2 mtvec, 3 mepc)
//   trap, trap_cause          one-cycle trap pulse, registered mcause code
//   state                     current state, for debug
module core_ctrl_fsm #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       mret,
  input  logic       invalid,
  input  logic       br_taken,
  input  logic [1:0] mem_addr_lo,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic       trap,
  output logic [3:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_FENCE  = 5'b00011;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] WAIT_SAT  = '1;

  state_t           state_q, state_d;
  logic [3:0]       cause_q, cause_d;
  logic [CNT_W-1:0] wait_q,  wait_d;
  logic             timeout;
  logic             is_store;
  logic             misalign;

  assign is_store = (opcode == OP_STORE);
  // The last waiting cycle is treated as a timeout only when no ack arrives on it.
  assign timeout  = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

`ifdef CTRL_MISALIGN_TRAP_EN
  logic unused_f3;
  assign unused_f3 = func3[2];
  // A half access needs addr[0]==0. A word access needs addr[1:0]==00. Bytes always pass.
  assign misalign  = ((func3[1:0] == 2'b01) && mem_addr_lo[0]) ||
                     ((func3[1:0] == 2'b10) && (mem_addr_lo != 2'b00));
`else
  logic unused_align;
  assign unused_align = ^{func3, mem_addr_lo};
  assign misalign     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= 4'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 4'd1;
        end
      end
      S_DECODE: begin
        if (invalid) begin
          state_d = S_TRAP;
          cause_d = 4'd2;
        end else if (ecall) begin
          state_d = S_TRAP;
          cause_d = 4'd11;
        end else if (ebreak) begin
          state_d = S_TRAP;
          cause_d = 4'd3;
        end else if (mret) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: begin
            if (misalign) begin
              state_d = S_TRAP;
              cause_d = is_store ? 4'd6 : 4'd4;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE: state_d = S_FETCH;
          default:                              state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = is_store ? 4'd7 : 4'd5;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // The wait counter counts only while a request stays pending in the same state.
    if ((state_d != state_q) || imem_ack || dmem_ack) begin
      wait_d = '0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && (wait_q != WAIT_SAT)) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Output logic. Reset forces every strobe low, even in the middle of a request.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    rf_we    = 1'b0;
    trap     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_DECODE: begin
          if (!invalid && !ecall && !ebreak && mret) begin
            pc_we  = 1'b1;
            pc_sel = 2'd3;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = br_taken ? 2'd1 : 2'd0;
            end
            OP_JAL, OP_JALR: begin
              rf_we  = 1'b1;
              pc_we  = 1'b1;
              pc_sel = 2'd1;
            end
            OP_FENCE: pc_we = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          pc_we    = dmem_ack && is_store;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        S_TRAP: begin
          trap   = 1'b1;
          pc_we  = 1'b1;
          pc_sel = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
module tb_core_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic       ecall, ebreak, mret, invalid, br_taken;
  logic [1:0] mem_addr_lo;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0] pc_sel;
  logic [3:0] trap_cause;
  logic [2:0] state;

  always #5 clk = ~clk;

  core_ctrl_fsm #(.MAX_WAIT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
    .ecall(ecall), .ebreak(ebreak), .mret(mret), .invalid(invalid),
    .br_taken(br_taken), .mem_addr_lo(mem_addr_lo),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  localparam logic [4:0] OP = 5'b01100, LD = 5'b00000, ST = 5'b01000;
  localparam logic [4:0] BR = 5'b11000, JL = 5'b11011, JR = 5'b11001, FN = 5'b00011;

  // Output vector: {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,rf_we,trap,trap_cause,state}
  logic [15:0] act;
  assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, trap, trap_cause, state};

  typedef struct {
    int          tid;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [3:0]  strb;   // {invalid, ecall, ebreak, mret}
    logic        bt;
    logic [1:0]  alo;
    logic        iack;
    logic        dack;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [15:0] E(input logic ir, input logic dr, input logic dw,
                                    input logic iw, input logic pw, input logic [1:0] ps,
                                    input logic rf, input logic tr, input logic [3:0] c,
                                    input logic [2:0] st);
    return {ir, dr, dw, iw, pw, ps, rf, tr, c, st};
  endfunction

  task automatic add(input int tid, input logic [4:0] op, input logic [2:0] f3,
                     input logic [3:0] strb, input logic bt, input logic [1:0] alo,
                     input logic iack, input logic dack, input logic [15:0] exp);
    vec_t v;
    v.tid = tid; v.op = op; v.f3 = f3; v.strb = strb; v.bt = bt;
    v.alo = alo; v.iack = iack; v.dack = dack; v.exp = exp;
    vq.push_back(v);
  endtask

  // Fetch with ack on the first cycle, then a plain decode cycle.
  task automatic fd(input int tid, input logic [4:0] op, input logic [2:0] f3,
                    input logic [1:0] alo, input logic [3:0] c);
    add(tid, op, f3, 4'b0000, 1'b0, alo, 1'b1, 1'b0, E(1,0,0,1,0,2'd0,0,0,c,3'd0));
    add(tid, op, f3, 4'b0000, 1'b0, alo, 1'b0, 1'b0, E(0,0,0,0,0,2'd0,0,0,c,3'd1));
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // 1: register-register op through WB
    add(1, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(1,0,0,0,0,2'd0,0,0,4'd0,3'd0));
    fd(1, OP, 3'd0, 2'd0, 4'd0);
    add(1, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd0,3'd2));
    add(1, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd0,1,0,4'd0,3'd4));
    // 2: load with ack after 3 wait cycles
    fd(2, LD, 3'b010, 2'd0, 4'd0);
    add(2, LD, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd0,3'd2));
    for (int i = 0; i < 3; i++)
      add(2, LD, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,1,0,0,0,2'd0,0,0,4'd0,3'd3));
    add(2, LD, 3'b010, 4'b0, 0, 2'd0, 0, 1, E(0,1,0,0,0,2'd0,0,0,4'd0,3'd3));
    add(2, LD, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd0,1,0,4'd0,3'd4));
    // 3: store, immediate ack, straight back to FETCH
    fd(3, ST, 3'b010, 2'd0, 4'd0);
    add(3, ST, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd0,3'd2));
    add(3, ST, 3'b010, 4'b0, 0, 2'd0, 0, 1, E(0,1,1,0,1,2'd0,0,0,4'd0,3'd3));
    // 5-7: branch taken / not taken, JAL, JALR, FENCE
    fd(5, BR, 3'd0, 2'd0, 4'd0);
    add(5, BR, 3'd0, 4'b0, 1, 2'd0, 0, 0, E(0,0,0,0,1,2'd1,0,0,4'd0,3'd2));
    fd(5, BR, 3'd0, 2'd0, 4'd0);
    add(5, BR, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd0,0,0,4'd0,3'd2));
    fd(6, JL, 3'd0, 2'd0, 4'd0);
    add(6, JL, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd1,1,0,4'd0,3'd2));
    fd(6, JR, 3'd0, 2'd0, 4'd0);
    add(6, JR, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd1,1,0,4'd0,3'd2));
    fd(7, FN, 3'd0, 2'd0, 4'd0);
    add(7, FN, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd0,0,0,4'd0,3'd2));
    // 8-12: decode traps, priority, mret
    add(8, OP, 3'd0, 4'b0, 0, 2'd0, 1, 0, E(1,0,0,1,0,2'd0,0,0,4'd0,3'd0));
    add(8, OP, 3'd0, 4'b1000, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd0,3'd1));
    add(8, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd2,3'd5));
    add(9, OP, 3'd0, 4'b0, 0, 2'd0, 1, 0, E(1,0,0,1,0,2'd0,0,0,4'd2,3'd0));
    add(9, OP, 3'd0, 4'b0100, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd2,3'd1));
    add(9, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd11,3'd5));
    add(10, OP, 3'd0, 4'b0, 0, 2'd0, 1, 0, E(1,0,0,1,0,2'd0,0,0,4'd11,3'd0));
    add(10, OP, 3'd0, 4'b1100, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd11,3'd1));
    add(10, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd2,3'd5));
    add(11, OP, 3'd0, 4'b0, 0, 2'd0, 1, 0, E(1,0,0,1,0,2'd0,0,0,4'd2,3'd0));
    add(11, OP, 3'd0, 4'b0011, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd2,3'd1));
    add(11, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd3,3'd5));
    add(12, OP, 3'd0, 4'b0, 0, 2'd0, 1, 0, E(1,0,0,1,0,2'd0,0,0,4'd3,3'd0));
    add(12, OP, 3'd0, 4'b0001, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd3,0,0,4'd3,3'd1));
    // 13: fetch timeout after 8 cycles without ack
    for (int i = 0; i < 8; i++)
      add(13, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(1,0,0,0,0,2'd0,0,0,4'd3,3'd0));
    add(13, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd1,3'd5));
    // 14: ack on the 8th cycle wins over the timeout
    for (int i = 0; i < 7; i++)
      add(14, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(1,0,0,0,0,2'd0,0,0,4'd1,3'd0));
    fd(14, OP, 3'd0, 2'd0, 4'd1);
    add(14, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd1,3'd2));
    add(14, OP, 3'd0, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd0,1,0,4'd1,3'd4));
    // 15/16: data bus timeout on load (cause 5) and store (cause 7)
    fd(15, LD, 3'b010, 2'd0, 4'd1);
    add(15, LD, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd1,3'd2));
    for (int i = 0; i < 8; i++)
      add(15, LD, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,1,0,0,0,2'd0,0,0,4'd1,3'd3));
    add(15, LD, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd5,3'd5));
    fd(16, ST, 3'b010, 2'd0, 4'd5);
    add(16, ST, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd5,3'd2));
    for (int i = 0; i < 8; i++)
      add(16, ST, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,1,1,0,0,2'd0,0,0,4'd5,3'd3));
    add(16, ST, 3'b010, 4'b0, 0, 2'd0, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd7,3'd5));
    // 17: word load from addr_lo=2
    fd(17, LD, 3'b010, 2'd2, 4'd7);
    add(17, LD, 3'b010, 4'b0, 0, 2'd2, 0, 0, E(0,0,0,0,0,2'd0,0,0,4'd7,3'd2));
`ifdef CTRL_MISALIGN_TRAP_EN
    add(17, LD, 3'b010, 4'b0, 0, 2'd2, 0, 0, E(0,0,0,0,1,2'd2,0,1,4'd4,3'd5));
`else
    add(17, LD, 3'b010, 4'b0, 0, 2'd2, 0, 1, E(0,1,0,0,0,2'd0,0,0,4'd7,3'd3));
    add(17, LD, 3'b010, 4'b0, 0, 2'd2, 0, 0, E(0,0,0,0,1,2'd0,1,0,4'd7,3'd4));
`endif

    // Reset: every strobe low while rst is high, even with acks present
    rst = 1'b1; opcode = OP; func3 = 3'd0; {invalid, ecall, ebreak, mret} = 4'b0;
    br_taken = 1'b0; mem_addr_lo = 2'd0; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset", act, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      opcode = vq[i].op; func3 = vq[i].f3; {invalid, ecall, ebreak, mret} = vq[i].strb;
      br_taken = vq[i].bt; mem_addr_lo = vq[i].alo;
      imem_ack = vq[i].iack; dmem_ack = vq[i].dack;
      #1 chk($sformatf("vec%0d test%0d", i, vq[i].tid), act, vq[i].exp);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of MEM drops the request immediately
    opcode = ST; func3 = 3'd0; {invalid, ecall, ebreak, mret} = 4'b0;
    mem_addr_lo = 2'd0; imem_ack = 1'b1; dmem_ack = 1'b0;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mem_before_rst", {dmem_req, dmem_we, 11'd0, state}, {1'b1, 1'b1, 11'd0, 3'd3});
    #1 rst = 1'b1;
    #1 chk("async_rst", act, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("first_after_rst", act, E(1,0,0,0,0,2'd0,0,0,4'd0,3'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
